lzc_mask_builder: RTL and testbench

//  Inverse of the leading/trailing-zero counter: consumes a stream of bit indices (count + empty

---
 rtl/lzc_mask_builder.sv | 98 +++++++++
 tb/tb_lzc_mask_builder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lzc_mask_builder.sv
// Rebuilds a bit vector from a stream of zero-count indices, OR-accumulating beats per frame
// and presenting each finished frame on a valid/ready output register.
//   state | meaning
//   ACCUM | collecting beats of the current frame, no result pending
//   HOLD  | finished frame on the outputs, waiting for the downstream handshake
module lzc_mask_builder #(
  parameter int WIDTH     = 8,
  parameter bit MODE      = 1'b0,
  parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 empty_i,
  input  logic                 last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     mask_o,
  output logic [CNT_WIDTH:0]   beats_o,
  output logic                 dup_o,
  output logic                 err_o
);

  localparam int BW = CNT_WIDTH + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [BW-1:0]    acc_beats;
  logic             acc_dup;
  logic             acc_err;

  logic [WIDTH-1:0] beat_bit;
  logic [WIDTH-1:0] nxt_acc;
  logic [BW-1:0]    nxt_beats;
  logic             nxt_dup;
  logic             nxt_err;
  logic             in_range;
  logic             accept;

  assign in_ready_o  = (state == ACCUM) || out_ready_i;
  assign out_valid_o = (state == HOLD);
  assign accept      = in_valid_i && in_ready_o;
  assign in_range    = ({1'b0, cnt_i} < BW'(WIDTH));

  // Out-of-range indices match no position, so they never set a bit.
  always_comb begin
    beat_bit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!empty_i && (cnt_i == CNT_WIDTH'(MODE ? (WIDTH - 1 - i) : i)))
        beat_bit[i] = 1'b1;
    end
  end

  // acc is already clear whenever we sit in HOLD, so the fold is the same in both states.
  assign nxt_acc   = acc | beat_bit;
  assign nxt_dup   = acc_dup | (|(acc & beat_bit));
  assign nxt_err   = acc_err | (!empty_i && !in_range);
  assign nxt_beats = (acc_beats == '1) ? acc_beats : acc_beats + BW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ACCUM;
      acc       <= '0;
      acc_beats <= '0;
      acc_dup   <= 1'b0;
      acc_err   <= 1'b0;
      mask_o    <= '0;
      beats_o   <= '0;
      dup_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (accept && last_i) begin
        mask_o    <= nxt_acc;
        beats_o   <= nxt_beats;
        dup_o     <= nxt_dup;
        err_o     <= nxt_err;
        acc       <= '0;
        acc_beats <= '0;
        acc_dup   <= 1'b0;
        acc_err   <= 1'b0;
        state     <= HOLD;
      end else if (accept) begin
        acc       <= nxt_acc;
        acc_beats <= nxt_beats;
        acc_dup   <= nxt_dup;
        acc_err   <= nxt_err;
        state     <= ACCUM;
      end else if (state == HOLD && out_ready_i) begin
        state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_lzc_mask_builder.sv
// Directed and random checks of lzc_mask_builder; three instances (W8/M0, W8/M1, W6/M0)
// share one input stream since all use a 3-bit index.
module tb_lzc_mask_builder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] cnt;
  logic       empty;
  logic       last;
  logic       out_ready;

  logic       rdy0, vld0, dup0, err0;
  logic [7:0] mask0;
  logic [3:0] beats0;
  logic       rdy1, vld1, dup1, err1;
  logic [7:0] mask1;
  logic [3:0] beats1;
  logic       rdy2, vld2, dup2, err2;
  logic [5:0] mask2;
  logic [3:0] beats2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lzc_mask_builder #(.WIDTH(8), .MODE(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy0), .cnt_i(cnt),
    .empty_i(empty), .last_i(last), .out_valid_o(vld0), .out_ready_i(out_ready),
    .mask_o(mask0), .beats_o(beats0), .dup_o(dup0), .err_o(err0));

  lzc_mask_builder #(.WIDTH(8), .MODE(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1), .cnt_i(cnt),
    .empty_i(empty), .last_i(last), .out_valid_o(vld1), .out_ready_i(out_ready),
    .mask_o(mask1), .beats_o(beats1), .dup_o(dup1), .err_o(err1));

  lzc_mask_builder #(.WIDTH(6), .MODE(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy2), .cnt_i(cnt),
    .empty_i(empty), .last_i(last), .out_valid_o(vld2), .out_ready_i(out_ready),
    .mask_o(mask2), .beats_o(beats2), .dup_o(dup2), .err_o(err2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input int c, input bit e, input bit l);
    in_valid = 1'b1;
    cnt      = c[2:0];
    empty    = e;
    last     = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    empty    = 1'b0;
    last     = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // reference model state for the random phase (WIDTH=8, MODE=0)
  bit       m_hold, m_dup, m_err, o_dup, o_err, m_rdy, m_acc_now, pend;
  bit [7:0] m_acc, o_mask, m_bit;
  int       m_beats, o_beats, n_beats, accepted;

  initial begin
    rst = 1'b1; in_valid = 1'b0; cnt = '0; empty = 1'b0; last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", vld0, 0);
    chk("rst_mask", mask0, 0);
    chk("rst_beats", beats0, 0);
    chk("rst_rdy", rdy0, 1);
    rst = 1'b0;

    // T1
    beat(3, 0, 0); beat(0, 0, 0);
    chk("t1_mid_vld", vld0, 0);
    beat(7, 0, 1);
    chk("t1_vld", vld0, 1);
    chk("t1_mask", mask0, 8'h89);
    chk("t1_beats", beats0, 3);
    chk("t1_dup", dup0, 0);
    chk("t1_err", err0, 0);
    chk("t1_m1_mask", mask1, 8'h91);
    chk("t1_w6_mask", mask2, 6'h09);
    chk("t1_w6_err", err2, 1);
    drain();
    chk("t1_drain_vld", vld0, 0);

    // T2
    beat(0, 0, 1);
    chk("t2_mask", mask1, 8'h80);
    chk("t2_beats", beats1, 1);
    drain();
    beat(0, 1, 1);
    chk("t2e_vld", vld1, 1);
    chk("t2e_mask", mask1, 8'h00);
    chk("t2e_beats", beats1, 1);
    chk("t2e_dup", dup1, 0);
    chk("t2e_err", err1, 0);
    drain();

    // T3
    beat(2, 0, 0); beat(2, 0, 0); beat(6, 0, 1);
    chk("t3_mask", mask2, 6'h04);
    chk("t3_dup", dup2, 1);
    chk("t3_err", err2, 1);
    chk("t3_beats", beats2, 3);
    chk("t3_w8_mask", mask0, 8'h44);
    chk("t3_w8_err", err0, 0);
    chk("t3_w8_dup", dup0, 1);

    // T4: backpressure with a last beat waiting
    in_valid = 1'b1; cnt = 3'd1; last = 1'b1; empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_rdy", rdy0, 0);
      chk("t4_vld", vld0, 1);
      chk("t4_mask", mask0, 8'h44);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("t4_rdy_comb", rdy0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; last = 1'b0;
    chk("t4_b2b_vld", vld0, 1);
    chk("t4_b2b_mask", mask0, 8'h02);
    chk("t4_b2b_beats", beats0, 1);
    chk("t4_b2b_dup", dup0, 0);
    drain();
    chk("t4_done_vld", vld0, 0);

    // T5: reset mid-frame, then in HOLD
    beat(1, 0, 0); beat(2, 0, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("t5a_vld", vld0, 0);
    chk("t5a_mask", mask0, 0);
    chk("t5a_rdy", rdy0, 1);
    beat(5, 0, 1);
    chk("t5a_res_mask", mask0, 8'h20);
    chk("t5a_res_beats", beats0, 1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("t5b_vld", vld0, 0);
    chk("t5b_mask", mask0, 0);
    chk("t5b_beats", beats0, 0);
    chk("t5b_err", err0, 0);
    chk("t5b_rdy", rdy0, 1);
    beat(5, 0, 1);
    chk("t5b_res_mask", mask0, 8'h20);
    chk("t5b_res_beats", beats0, 1);
    drain();

    // saturation: 40-beat frame
    for (int i = 0; i < 40; i++) beat(i % 8, 0, i == 39);
    chk("sat_beats", beats0, 15);
    chk("sat_mask", mask0, 8'hff);
    chk("sat_dup", dup0, 1);
    drain();

    // T6: random stream against the reference model
    m_hold = 0; m_acc = '0; m_beats = 0; m_dup = 0; m_err = 0;
    o_mask = '0; o_beats = 0; o_dup = 0; o_err = 0; pend = 0; accepted = 0;
    for (int cyc = 0; cyc < 40000 && accepted < 10000; cyc++) begin
      chk("rnd_vld", vld0, m_hold);
      if (m_hold) begin
        chk("rnd_mask", mask0, o_mask);
        chk("rnd_beats", beats0, o_beats);
        chk("rnd_dup", dup0, o_dup);
        chk("rnd_err", err0, o_err);
      end
      if (!pend) begin
        in_valid = ($urandom_range(0, 4) != 0);
        cnt      = 3'($urandom_range(0, 7));
        empty    = ($urandom_range(0, 7) == 0);
        last     = ($urandom_range(0, 15) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_rdy = !m_hold || out_ready;
      chk("rnd_rdy", rdy0, m_rdy);
      m_acc_now = in_valid && m_rdy;
      pend = in_valid && !m_acc_now;
      m_bit = empty ? 8'h00 : (8'h01 << cnt);
      n_beats = (m_beats < 15) ? m_beats + 1 : 15;
      if (m_acc_now) begin
        accepted++;
        if (last) begin
          o_mask = m_acc | m_bit; o_beats = n_beats;
          o_dup = m_dup || ((m_acc & m_bit) != 0); o_err = m_err;
          m_acc = '0; m_beats = 0; m_dup = 0; m_err = 0;
          m_hold = 1;
        end else begin
          m_dup = m_dup || ((m_acc & m_bit) != 0);
          m_acc = m_acc | m_bit; m_beats = n_beats;
          m_hold = 0;
        end
      end else if (m_hold && out_ready) begin
        m_hold = 0;
      end
      @(posedge clk); #1;
    end
    chk("rnd_accepted", accepted, 10000);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
